// File: rtl/dobby_bus_fifo_periph_pkg.sv
// Shared definitions for the dobby bus FIFO peripheral: register map,
// STATUS/CTRL bit positions, bus FSM encodings and the latched request.
package dobby_bus_fifo_periph_pkg;

  // Register select is byte-offset[3:2]; offset[1:0] is don't-care.
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_IRQ    = 2'd3;

  localparam int ST_RX_EMPTY   = 0;
  localparam int ST_RX_FULL    = 1;
  localparam int ST_TX_EMPTY   = 2;
  localparam int ST_TX_FULL    = 3;
  localparam int ST_TX_OVF     = 8;
  localparam int ST_RX_UDF     = 9;
  localparam int ST_RX_CNT_LSB = 12;
  localparam int ST_TX_CNT_LSB = 16;

  localparam int CTRL_LB      = 0;
  localparam int CTRL_IRQ0_EN = 1;
  localparam int CTRL_IRQ1_EN = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;

  typedef struct packed {
    logic       we;
    logic       hit;
    logic [1:0] reg_sel;
    logic [9:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/dobby_bus_fifo_periph_if.sv
// Target-side SoC bus bundle; names keep the _i/_o sense as seen by the peripheral.
interface dobby_bus_fifo_periph_if;
  logic        bus_en_i;
  logic        bus_we_i;
  logic [1:0]  bus_size_i;
  logic [15:0] bus_addr_i;
  logic [31:0] bus_write_data_i;
  logic        bus_rdy_o;
  logic [31:0] bus_read_data_o;

  modport master (
    output bus_en_i, bus_we_i, bus_size_i, bus_addr_i, bus_write_data_i,
    input  bus_rdy_o, bus_read_data_o
  );

  modport slave (
    input  bus_en_i, bus_we_i, bus_size_i, bus_addr_i, bus_write_data_i,
    output bus_rdy_o, bus_read_data_o
  );
endinterface

// File: rtl/dobby_sync_fifo.sv
// Single-clock FIFO; push when full and pop when empty are silently blocked.
module dobby_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        din_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/dobby_bus_fifo_periph.sv
// Bus target with a 16-byte register window fronting TX/RX byte FIFOs,
// a loopback path, two interrupt lines and a valid/ready byte-stream bridge.
module dobby_bus_fifo_periph
  import dobby_bus_fifo_periph_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          WAIT_STATES = 1
) (
  input  logic                    clk_i,
  input  logic                    a_reset_h_i,
  dobby_bus_fifo_periph_if.slave  bus,
  output logic [1:0]              intr_h_o,
  input  logic [1:0]              intr_ack_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WS_W  = $clog2(WAIT_STATES + 2);

  logic [1:0]      state_q, state_d;
  logic [WS_W-1:0] wait_cnt_q, wait_cnt_d;
  bus_req_t        req_q, req_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [1:0]      pend_q, pend_d, irq_q, irq_d, irq_set, irq_clr;
  logic            tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic            live_q;

  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       tx_head, rx_head, rx_din;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic             acc, wr_acc, rd_acc, loopback, lb_move, st_w1c;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{bus.bus_size_i, bus.bus_addr_i[1:0], bus.bus_write_data_i[31:10]};

  // Bus FSM: IDLE -> [WAIT] -> ACK -> TURN; TURN ignores en so the master can drop it.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    case (state_q)
      S_IDLE: if (bus.bus_en_i) begin
        req_d = '{we:      bus.bus_we_i,
                  hit:     (bus.bus_addr_i[15:4] == BASE_ADDR[15:4]),
                  reg_sel: bus.bus_addr_i[3:2],
                  wdata:   bus.bus_write_data_i[9:0]};
        if (WAIT_STATES == 0) state_d = S_ACK;
        else begin
          state_d    = S_WAIT;
          wait_cnt_d = WS_W'(1);
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == WS_W'(WAIT_STATES)) state_d = S_ACK;
        else wait_cnt_d = wait_cnt_q + WS_W'(1);
      end
      S_ACK:   state_d = S_TURN;
      default: state_d = S_IDLE;
    endcase
  end

  assign acc      = (state_q == S_ACK) & req_q.hit;
  assign wr_acc   = acc & req_q.we;
  assign rd_acc   = acc & ~req_q.we;
  assign st_w1c   = wr_acc & (req_q.reg_sel == REG_STATUS);
  assign loopback = ctrl_q[CTRL_LB];

  // Loopback steals both stream ports and moves one byte per cycle TX -> RX.
  assign lb_move    = loopback & ~tx_empty & ~rx_full;
  assign tx_valid_o = ~tx_empty & ~loopback;
  assign rx_ready_o = live_q & ~rx_full & ~loopback;
  assign tx_data_o  = tx_empty ? 8'h00 : tx_head;

  assign tx_push = wr_acc & (req_q.reg_sel == REG_DATA);
  assign tx_pop  = lb_move | (tx_valid_o & tx_ready_i);
  assign rx_push = lb_move | (rx_valid_i & rx_ready_o);
  assign rx_din  = loopback ? tx_head : rx_data_i;
  assign rx_pop  = rd_acc & (req_q.reg_sel == REG_DATA);

  dobby_sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(a_reset_h_i), .push_i(tx_push), .din_i(req_q.wdata[7:0]),
    .pop_i(tx_pop), .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
  );

  dobby_sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(a_reset_h_i), .push_i(rx_push), .din_i(rx_din),
    .pop_i(rx_pop), .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
  );

  // Edge detects are on the FIFO's next-state: a push into empty RX, or a
  // lone pop of the last TX byte. Set beats any clear in the same cycle.
  always_comb begin
    irq_set[0] = rx_empty & rx_push;
    irq_set[1] = (tx_cnt == CNT_W'(1)) & tx_pop & ~tx_push;
    irq_clr    = intr_ack_i |
                 ({2{wr_acc & (req_q.reg_sel == REG_IRQ)}} & req_q.wdata[1:0]);
    pend_d     = (pend_q & ~irq_clr) | irq_set;
    ctrl_d     = (wr_acc && req_q.reg_sel == REG_CTRL) ? req_q.wdata[2:0] : ctrl_q;
    irq_d      = pend_d & {ctrl_d[CTRL_IRQ1_EN], ctrl_d[CTRL_IRQ0_EN]};
    tx_ovf_d   = (tx_ovf_q & ~(st_w1c & req_q.wdata[8])) | (tx_push & tx_full);
    rx_udf_d   = (rx_udf_q & ~(st_w1c & req_q.wdata[9])) | (rx_pop & rx_empty);
  end

  always_comb begin
    rdata = '0;
    case (req_q.reg_sel)
      REG_DATA:   rdata[7:0] = rx_empty ? 8'h00 : rx_head;
      REG_STATUS: begin
        rdata[ST_RX_EMPTY]          = rx_empty;
        rdata[ST_RX_FULL]           = rx_full;
        rdata[ST_TX_EMPTY]          = tx_empty;
        rdata[ST_TX_FULL]           = tx_full;
        rdata[ST_TX_OVF]            = tx_ovf_q;
        rdata[ST_RX_UDF]            = rx_udf_q;
        rdata[ST_RX_CNT_LSB +: 4]   = 4'(rx_cnt);
        rdata[ST_TX_CNT_LSB +: 4]   = 4'(tx_cnt);
      end
      REG_CTRL:   rdata[2:0] = ctrl_q;
      default:    rdata[1:0] = pend_q;
    endcase
  end

  assign bus.bus_rdy_o       = (state_q == S_ACK);
  assign bus.bus_read_data_o = rd_acc ? rdata : 32'h0;
  assign intr_h_o            = irq_q;

  always_ff @(posedge clk_i or posedge a_reset_h_i) begin
    if (a_reset_h_i) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      req_q      <= '0;
      ctrl_q     <= '0;
      pend_q     <= '0;
      irq_q      <= '0;
      tx_ovf_q   <= 1'b0;
      rx_udf_q   <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
      ctrl_q     <= ctrl_d;
      pend_q     <= pend_d;
      irq_q      <= irq_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_udf_q   <= rx_udf_d;
      live_q     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dobby_bus_fifo_periph.sv
// Directed bench for dobby_bus_fifo_periph with default parameters (WAIT_STATES=1, depth 8).
module tb_dobby_bus_fifo_periph;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] intr_h, intr_ack = 2'b00;
  logic [7:0] tx_data, rx_data = 8'h00;
  logic       tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready;
  int         vecs = 0;
  int         errs = 0;

  dobby_bus_fifo_periph_if bif();

  dobby_bus_fifo_periph dut (
    .clk_i(clk), .a_reset_h_i(rst), .bus(bif),
    .intr_h_o(intr_h), .intr_ack_i(intr_ack),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready)
  );

  always #5 clk = ~clk;

  // One bus access; returns read data and en-to-rdy latency, then lets the FSM return to IDLE.
  task automatic bus_xfer(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    @(negedge clk);
    bif.bus_en_i = 1'b1; bif.bus_we_i = we; bif.bus_addr_i = addr;
    bif.bus_write_data_i = wd; bif.bus_size_i = 2'b00;
    rd = 32'h0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bif.bus_rdy_o) begin rd = bif.bus_read_data_o; lat = i; break; end
    end
    bif.bus_en_i = 1'b0; bif.bus_we_i = 1'b0;
    if (lat < 0) begin
      errs++;
      $display("FAIL bus_timeout addr=%h got no rdy, want rdy within 20 cycles", addr);
    end
    vecs++;
    @(posedge clk); @(posedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat; bit seen;
    @(posedge clk); #1;
    if ({bif.bus_rdy_o, bif.bus_read_data_o, intr_h, tx_valid, rx_ready, tx_data} !== '0) begin
      errs++; $display("FAIL reset_outputs got rdy=%b rd=%h irq=%b txv=%b rxr=%b txd=%h want all 0",
                       bif.bus_rdy_o, bif.bus_read_data_o, intr_h, tx_valid, rx_ready, tx_data);
    end
    vecs++;
    @(negedge clk); rst = 1'b0;
    // Start a CTRL write, then reset while the FSM sits in WAIT.
    @(negedge clk);
    bif.bus_en_i = 1'b1; bif.bus_we_i = 1'b1; bif.bus_addr_i = 16'h8008; bif.bus_write_data_i = 32'h7;
    @(posedge clk); #1;
    rst = 1'b1; seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bif.bus_rdy_o) seen = 1;
    end
    bif.bus_en_i = 1'b0; bif.bus_we_i = 1'b0;
    if (seen) begin errs++; $display("FAIL abort_no_rdy got rdy=1 want 0"); end
    vecs++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    if (rx_ready !== 1'b1) begin errs++; $display("FAIL rx_ready_post_reset got %b want 1", rx_ready); end
    vecs++;
    bus_xfer(1'b0, 16'h8008, 32'h0, rd, lat);
    if (rd !== 32'h0) begin errs++; $display("FAIL ctrl_after_abort got %h want 0", rd); end
    vecs++;
    bus_xfer(1'b0, 16'h8004, 32'h0, rd, lat);
    if (rd !== 32'h0000_0005) begin errs++; $display("FAIL status_reset got %h want 00000005", rd); end
    vecs++;
  endtask

  task automatic test_ctrl_latency();
    logic [31:0] rd; int lat;
    bus_xfer(1'b1, 16'h8008, 32'h06, rd, lat);
    if (lat !== 2) begin errs++; $display("FAIL write_latency got %0d want 2", lat); end
    vecs++;
    bus_xfer(1'b0, 16'h8008, 32'h0, rd, lat);
    if (rd !== 32'h6 || lat !== 2) begin
      errs++; $display("FAIL ctrl_read got %h lat %0d want 00000006 lat 2", rd, lat);
    end
    vecs++;
    // STATUS is W1C on [9:8] only; this must not touch CTRL or STATUS.
    bus_xfer(1'b1, 16'h8004, 32'h06, rd, lat);
    bus_xfer(1'b0, 16'h8004, 32'h0, rd, lat);
    if (rd !== 32'h5) begin errs++; $display("FAIL status_after_w got %h want 00000005", rd); end
    vecs++;
    bus_xfer(1'b0, 16'h800B, 32'h0, rd, lat);
    if (rd !== 32'h6) begin errs++; $display("FAIL ctrl_low_bits_ignored got %h want 00000006", rd); end
    vecs++;
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1, n = 0; bit bad_data = 0;
    @(negedge clk);
    bif.bus_en_i = 1'b1; bif.bus_we_i = 1'b0; bif.bus_addr_i = 16'h8008;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (bif.bus_rdy_o) begin
        n++;
        if (first < 0) first = c; else second = c;
        if (bif.bus_read_data_o !== 32'h6) bad_data = 1;
      end else if (bif.bus_read_data_o !== 32'h0) bad_data = 1;
    end
    bif.bus_en_i = 1'b0;
    @(posedge clk);
    if (n !== 2 || first !== 2 || second !== 6) begin
      errs++; $display("FAIL b2b_timing got n=%0d at %0d,%0d want n=2 at 2,6", n, first, second);
    end
    vecs++;
    if (bad_data) begin errs++; $display("FAIL b2b_rdata got bad data want 6 on rdy, 0 otherwise"); end
    vecs++;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] rd; int lat; bit bad = 0;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_xfer(1'b1, 16'h8000, 32'h10 + i, rd, lat);
    bus_xfer(1'b0, 16'h8004, 32'h0, rd, lat);
    if (rd !== 32'h0008_0109) begin errs++; $display("FAIL tx_full_status got %h want 00080109", rd); end
    vecs++;
    bus_xfer(1'b1, 16'h8004, 32'h100, rd, lat);
    bus_xfer(1'b0, 16'h8004, 32'h0, rd, lat);
    if (rd !== 32'h0008_0009) begin errs++; $display("FAIL ovf_w1c got %h want 00080009", rd); end
    vecs++;
    @(negedge clk);
    if (intr_h !== 2'b00) begin errs++; $display("FAIL irq_before_drain got %b want 00", intr_h); end
    vecs++;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h10 + i)) bad = 1;
      @(posedge clk); @(negedge clk);
    end
    if (bad) begin errs++; $display("FAIL tx_drain_seq got wrong byte/valid want 10..17 valid"); end
    vecs++;
    if (tx_valid !== 1'b0 || intr_h !== 2'b10) begin
      errs++; $display("FAIL tx_drained got txv=%b irq=%b want txv=0 irq=10", tx_valid, intr_h);
    end
    vecs++;
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_irq();
    logic [31:0] rd; int lat;
    @(negedge clk);
    if (intr_h[0] !== 1'b0) begin errs++; $display("FAIL irq0_idle got %b want 0", intr_h[0]); end
    vecs++;
    rx_valid = 1'b1; rx_data = 8'hA5;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (intr_h[0] !== 1'b1) begin errs++; $display("FAIL irq0_next_cycle got %b want 1", intr_h[0]); end
    vecs++;
    bus_xfer(1'b0, 16'h8000, 32'h0, rd, lat);
    if (rd !== 32'hA5) begin errs++; $display("FAIL rx_read got %h want 000000a5", rd); end
    vecs++;
    bus_xfer(1'b0, 16'h8000, 32'h0, rd, lat);
    if (rd !== 32'h0) begin errs++; $display("FAIL rx_underflow_read got %h want 0", rd); end
    vecs++;
    bus_xfer(1'b0, 16'h8004, 32'h0, rd, lat);
    if (rd !== 32'h205) begin errs++; $display("FAIL udf_status got %h want 00000205", rd); end
    vecs++;
    bus_xfer(1'b1, 16'h8004, 32'h200, rd, lat);
    bus_xfer(1'b0, 16'h8004, 32'h0, rd, lat);
    if (rd !== 32'h5) begin errs++; $display("FAIL udf_w1c got %h want 00000005", rd); end
    vecs++;
  endtask

  task automatic test_ack_race();
    logic [31:0] rd; int lat;
    @(negedge clk); intr_ack = 2'b11;
    @(posedge clk); #1; intr_ack = 2'b00;
    if (intr_h !== 2'b00) begin errs++; $display("FAIL ack_clear_line got %b want 00", intr_h); end
    vecs++;
    bus_xfer(1'b0, 16'h800C, 32'h0, rd, lat);
    if (rd !== 32'h0) begin errs++; $display("FAIL ack_clear_pend got %h want 0", rd); end
    vecs++;
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h5A; intr_ack = 2'b01;
    @(posedge clk); #1; rx_valid = 1'b0; intr_ack = 2'b00;
    if (intr_h[0] !== 1'b1) begin errs++; $display("FAIL set_wins_line got %b want 1", intr_h[0]); end
    vecs++;
    bus_xfer(1'b0, 16'h800C, 32'h0, rd, lat);
    if (rd !== 32'h1) begin errs++; $display("FAIL set_wins_pend got %h want 00000001", rd); end
    vecs++;
    bus_xfer(1'b1, 16'h800C, 32'h1, rd, lat);
    bus_xfer(1'b0, 16'h800C, 32'h0, rd, lat);
    if (rd !== 32'h0 || intr_h !== 2'b00) begin
      errs++; $display("FAIL irq_w1c got %h line %b want 0 line 00", rd, intr_h);
    end
    vecs++;
    bus_xfer(1'b0, 16'h8000, 32'h0, rd, lat);
    if (rd !== 32'h5A) begin errs++; $display("FAIL rx_read2 got %h want 0000005a", rd); end
    vecs++;
  endtask

  task automatic test_loopback();
    logic [31:0] rd; int lat; bit txv_seen = 0;
    bus_xfer(1'b1, 16'h8008, 32'h7, rd, lat);
    if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
      errs++; $display("FAIL lb_ports got txv=%b rxr=%b want 0 0", tx_valid, rx_ready);
    end
    vecs++;
    bus_xfer(1'b1, 16'h8000, 32'h41, rd, lat);
    if (tx_valid) txv_seen = 1;
    bus_xfer(1'b1, 16'h8000, 32'h42, rd, lat);
    if (tx_valid) txv_seen = 1;
    bus_xfer(1'b0, 16'h800C, 32'h0, rd, lat);
    if (rd !== 32'h3) begin errs++; $display("FAIL lb_pending got %h want 00000003", rd); end
    vecs++;
    bus_xfer(1'b0, 16'h8000, 32'h0, rd, lat);
    if (rd !== 32'h41) begin errs++; $display("FAIL lb_read1 got %h want 00000041", rd); end
    vecs++;
    bus_xfer(1'b0, 16'h8000, 32'h0, rd, lat);
    if (rd !== 32'h42) begin errs++; $display("FAIL lb_read2 got %h want 00000042", rd); end
    vecs++;
    if (txv_seen || tx_valid) begin errs++; $display("FAIL lb_tx_valid got 1 want 0"); end
    vecs++;
    bus_xfer(1'b0, 16'h0000, 32'h0, rd, lat);
    if (rd !== 32'h0 || lat !== 2) begin
      errs++; $display("FAIL oow_read got %h lat %0d want 0 lat 2", rd, lat);
    end
    vecs++;
    bus_xfer(1'b1, 16'h0008, 32'h0, rd, lat);
    bus_xfer(1'b0, 16'h8008, 32'h0, rd, lat);
    if (rd !== 32'h7) begin errs++; $display("FAIL oow_write_ignored got %h want 00000007", rd); end
    vecs++;
    bus_xfer(1'b0, 16'h8004, 32'h0, rd, lat);
    if (rd !== 32'h5) begin errs++; $display("FAIL lb_final_status got %h want 00000005", rd); end
    vecs++;
  endtask

  initial begin
    bif.bus_en_i = 1'b0; bif.bus_we_i = 1'b0; bif.bus_size_i = 2'b00;
    bif.bus_addr_i = 16'h0; bif.bus_write_data_i = 32'h0;
    test_reset();
    test_ctrl_latency();
    test_back_to_back();
    test_tx_overflow();
    test_rx_irq();
    test_ack_race();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
